// File: rtl/if_pkg.sv
// if_pkg: shared state encoding and constants for the instruction fetch stage
package if_pkg;
   localparam int XLEN    = 32;
   localparam int PC_STEP = 4;
   typedef enum logic [2:0] {IDLE, REQ, HOLD, SQUASH, FAULT} state_t;
endpackage

// File: rtl/fetch_buffer.sv
// fetch_buffer: IF/ID pipeline register backed by a one-entry skid buffer
//   clk, reset (async, active-low)
//   stall            decode cannot accept a new entry
//   flush            drop both IF/ID and skid contents
//   load/load_instr/load_pc  returned word to capture
//   free             IF/ID can take a word this edge
//   if_valid/if_instr/if_pc  IF/ID entry presented to decode
module fetch_buffer #(
   parameter int              XLEN      = if_pkg::XLEN,
   parameter logic [XLEN-1:0] NOP_INSTR = '0
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            stall,
   input  logic            flush,
   input  logic            load,
   input  logic [XLEN-1:0] load_instr,
   input  logic [XLEN-1:0] load_pc,
   output logic            free,
   output logic            if_valid,
   output logic [XLEN-1:0] if_instr,
   output logic [XLEN-1:0] if_pc
);
   logic            skid_valid;
   logic [XLEN-1:0] skid_instr;
   logic [XLEN-1:0] skid_pc;
   assign free = !if_valid || !stall;
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         if_valid   <= 1'b0;
         if_instr   <= NOP_INSTR;
         if_pc      <= '0;
         skid_valid <= 1'b0;
         skid_instr <= NOP_INSTR;
         skid_pc    <= '0;
      end else if (flush) begin
         if_valid   <= 1'b0;
         if_instr   <= NOP_INSTR;
         skid_valid <= 1'b0;
      end else if (skid_valid && !stall) begin
         if_valid   <= 1'b1;
         if_instr   <= skid_instr;
         if_pc      <= skid_pc;
         skid_valid <= 1'b0;
      end else if (load && free) begin
         if_valid   <= 1'b1;
         if_instr   <= load_instr;
         if_pc      <= load_pc;
      end else if (load) begin
         skid_valid <= 1'b1;
         skid_instr <= load_instr;
         skid_pc    <= load_pc;
      end else if (!stall) begin
         // entry consumed (or already empty) with nothing to replace it
         if_valid   <= 1'b0;
         if_instr   <= NOP_INSTR;
      end
   end
endmodule

// File: rtl/instruction_fetch.sv
// instruction_fetch: single-outstanding fetch stage feeding the IF/ID register
//   clk, reset (async, active-low)
//   pc / pc_next / pc_write       handshake with program_counter
//   imem_req / imem_addr / imem_ready / imem_rdata  instruction memory port
//   stall, redirect, redirect_target                 from decode / branch unit
//   if_valid / if_instr / if_pc                      IF/ID entry
//   fetch_fault                   misaligned fetch flag
// Optional feature: define FETCH_MISALIGN_CHECK_EN to trap fetches with pc[1:0]!=0.
module instruction_fetch #(
   parameter int              XLEN      = if_pkg::XLEN,
   parameter logic [XLEN-1:0] NOP_INSTR = '0
) (
   input  logic            clk,
   input  logic            reset,
   input  logic [XLEN-1:0] pc,
   output logic [XLEN-1:0] pc_next,
   output logic            pc_write,
   output logic            imem_req,
   output logic [XLEN-1:0] imem_addr,
   input  logic            imem_ready,
   input  logic [XLEN-1:0] imem_rdata,
   input  logic            stall,
   input  logic            redirect,
   input  logic [XLEN-1:0] redirect_target,
   output logic            if_valid,
   output logic [XLEN-1:0] if_instr,
   output logic [XLEN-1:0] if_pc,
   output logic            fetch_fault
);
   import if_pkg::*;
   state_t          state;
   state_t          state_nxt;
   logic [XLEN-1:0] req_addr_q;
   logic [XLEN-1:0] pc_aligned;
   logic            load;
   logic            free;
   logic            misaligned;
   assign pc_aligned = {pc[XLEN-1:2], 2'b00};
`ifdef FETCH_MISALIGN_CHECK_EN
   assign misaligned  = |pc[1:0];
   assign fetch_fault = reset && (state == FAULT || (state == REQ && misaligned));
`else
   assign misaligned  = 1'b0;
   assign fetch_fault = 1'b0;
`endif
   always_comb begin
      state_nxt = state;
      imem_req  = 1'b0;
      imem_addr = '0;
      pc_write  = 1'b0;
      pc_next   = '0;
      load      = 1'b0;
      case (state)
         IDLE:   state_nxt = REQ;
         REQ: begin
            if (misaligned) state_nxt = FAULT;
            else begin
               imem_req  = 1'b1;
               imem_addr = pc_aligned;
               if (imem_ready) begin
                  pc_write  = 1'b1;
                  pc_next   = pc + XLEN'(PC_STEP);
                  load      = 1'b1;
                  state_nxt = free ? REQ : HOLD;
               end
            end
         end
         HOLD:   state_nxt = stall ? HOLD : REQ;
         SQUASH: begin
            // the already-issued request must finish before a new address goes out
            imem_req  = 1'b1;
            imem_addr = req_addr_q;
            state_nxt = imem_ready ? REQ : SQUASH;
         end
         FAULT:  state_nxt = FAULT;
         default: state_nxt = IDLE;
      endcase
      if (redirect) begin
         pc_write  = 1'b1;
         pc_next   = redirect_target;
         load      = 1'b0;
         state_nxt = (imem_req && !imem_ready) ? SQUASH : REQ;
      end
      if (!reset) begin
         imem_req  = 1'b0;
         imem_addr = '0;
         pc_write  = 1'b0;
         pc_next   = '0;
         load      = 1'b0;
      end
   end
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state      <= IDLE;
         req_addr_q <= '0;
      end else begin
         state <= state_nxt;
         if (state == REQ && imem_req) req_addr_q <= pc_aligned;
      end
   end
   fetch_buffer #(.XLEN(XLEN), .NOP_INSTR(NOP_INSTR)) u_buf (
      .clk        (clk),
      .reset      (reset),
      .stall      (stall),
      .flush      (redirect),
      .load       (load),
      .load_instr (imem_rdata),
      .load_pc    (pc),
      .free       (free),
      .if_valid   (if_valid),
      .if_instr   (if_instr),
      .if_pc      (if_pc)
   );
endmodule
